// File: rtl/scorpion_pkg.sv
// Shared scorpion definitions: action codes, actuator PIO patterns and
// scheduler state encodings, used by the behaviour FSM, the scheduler and the top level.
package scorpion_pkg;

    localparam logic [1:0] ACT_WAIT    = 2'b00;
    localparam logic [1:0] ACT_RETREAT = 2'b01;
    localparam logic [1:0] ACT_ATTACK  = 2'b10;
    localparam logic [1:0] ACT_DART    = 2'b11;

    // Bit 0 drives PIO76, bit 3 drives PIO79.
    localparam logic [3:0] PIO_WAIT    = 4'b0000;
    localparam logic [3:0] PIO_RETREAT = 4'b0001;
    localparam logic [3:0] PIO_ATTACK  = 4'b1010;
    localparam logic [3:0] PIO_DART    = 4'b0100;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

    function automatic logic [3:0] pio_pattern(input logic [1:0] action);
        logic [3:0] pat;
        case (action)
            ACT_RETREAT: pat = PIO_RETREAT;
            ACT_ATTACK:  pat = PIO_ATTACK;
            ACT_DART:    pat = PIO_DART;
            default:     pat = PIO_WAIT;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/scorpion_act_sched.sv
// Actuator scheduler: enforces a minimum hold per action and an all-off dead gap
// between different actions. Optional macro SCORP_ACT_ESTOP_EN adds an estop input.
module scorpion_act_sched
    import scorpion_pkg::*;
#(
    parameter int DEAD_CYCLES = 50000,
    parameter int HOLD_CYCLES = 5000000,
    parameter int CNT_W       = 24
) (
    input  logic       clk,
    input  logic       reset,
`ifdef SCORP_ACT_ESTOP_EN
    input  logic       estop,
`endif
    input  logic       auto_req,
    input  logic [1:0] auto_action,
    input  logic       man_req,
    input  logic [1:0] man_action,
    output logic [3:0] pio,
    output logic [1:0] cur_action,
    output logic       grant_man,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_pio;
    logic [1:0]       r_action;
    logic             r_grant_man;
    logic             r_busy;

    logic [1:0]       w_target;
    logic             w_target_man;
    logic             w_kill;

    // Request arbitration: manual always wins over the behaviour FSM.
    always_comb begin
        w_target     = ACT_WAIT;
        w_target_man = 1'b0;
        if (man_req) begin
            w_target     = man_action;
            w_target_man = 1'b1;
        end else if (auto_req) begin
            w_target     = auto_action;
        end else begin
            w_target     = ACT_WAIT;
        end
    end

`ifdef SCORP_ACT_ESTOP_EN
    assign w_kill     = estop;
    // Estop cuts the drive immediately; the FSM follows at the next edge.
    assign pio        = estop ? PIO_WAIT : r_pio;
    assign cur_action = estop ? ACT_WAIT : r_action;
`else
    assign w_kill     = 1'b0;
    assign pio        = r_pio;
    assign cur_action = r_action;
`endif
    assign grant_man  = r_grant_man;
    assign busy       = r_busy;

    // Scheduler FSM with its shared hold/dead counter.
    always_ff @(posedge clk) begin
        if (!reset || w_kill) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pio       <= PIO_WAIT;
            r_action    <= ACT_WAIT;
            r_grant_man <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_target != ACT_WAIT) begin
                        r_state     <= ST_ACTIVE;
                        r_cnt       <= '0;
                        r_pio       <= pio_pattern(w_target);
                        r_action    <= w_target;
                        r_grant_man <= w_target_man;
                        r_busy      <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (r_cnt != HOLD_LAST) begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (w_target == r_action) begin
                        r_grant_man <= w_target_man;
                    end else begin
                        r_state     <= ST_DEAD;
                        r_cnt       <= '0;
                        r_pio       <= PIO_WAIT;
                        r_action    <= ACT_WAIT;
                        r_grant_man <= 1'b0;
                    end
                end
                ST_DEAD: begin
                    // Only the request seen on the final dead cycle matters.
                    if (r_cnt != DEAD_LAST) begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (w_target == ACT_WAIT) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state     <= ST_ACTIVE;
                        r_cnt       <= '0;
                        r_pio       <= pio_pattern(w_target);
                        r_action    <= w_target;
                        r_grant_man <= w_target_man;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_pio       <= PIO_WAIT;
                    r_action    <= ACT_WAIT;
                    r_grant_man <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
